// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes MIPS opcode/funct to the ALU function code,
// builds forwarded/immediate operands, registers them and holds them for
// multi-cycle mult/div behind a valid/ready handshake.
module alu_issue_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [15:0]      imm,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [1:0]       fwd_sel_a,
    input  logic [1:0]       fwd_sel_b,
    input  logic [WIDTH-1:0] ex_fwd,
    input  logic [WIDTH-1:0] mem_fwd,
    output logic [3:0]       FunctC,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             out_last,
    output logic             illegal_op
);

    localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [CNT_W-1:0] MUL_HOLD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_HOLD = CNT_W'(DIV_CYCLES - 1);

    logic [3:0]       r_funct_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_out_valid;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_funct_c;
    logic             w_legal;
    logic             w_use_imm;
    logic             w_sign_ext;
    logic [CNT_W-1:0] w_hold;
    logic [WIDTH-1:0] w_fwd_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_op_b;
    logic             w_in_ready;

    // Decode opcode/funct into function code, operand-B source and hold length
    always_comb begin
        w_funct_c  = 4'b0000;
        w_legal    = 1'b0;
        w_use_imm  = 1'b0;
        w_sign_ext = 1'b0;
        w_hold     = '0;
        case (opcode)
            OP_RTYPE: begin
                w_legal = 1'b1;
                case (funct)
                    FN_ADD:  w_funct_c = 4'b0010;
                    FN_SUB:  w_funct_c = 4'b0110;
                    FN_AND:  w_funct_c = 4'b0000;
                    FN_OR:   w_funct_c = 4'b0001;
                    FN_NOR:  w_funct_c = 4'b0011;
                    FN_XOR:  w_funct_c = 4'b0100;
                    FN_SLT:  w_funct_c = 4'b0111;
                    FN_MULT: begin
                        w_funct_c = 4'b1010;
                        w_hold    = MUL_HOLD;
                    end
                    FN_DIV: begin
                        w_funct_c = 4'b1111;
                        w_hold    = DIV_HOLD;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                w_legal    = 1'b1;
                w_funct_c  = 4'b0010;
                w_use_imm  = 1'b1;
                w_sign_ext = 1'b1;
            end
            OP_SLTI: begin
                w_legal    = 1'b1;
                w_funct_c  = 4'b0111;
                w_use_imm  = 1'b1;
                w_sign_ext = 1'b1;
            end
            OP_ANDI: begin
                w_legal   = 1'b1;
                w_funct_c = 4'b0000;
                w_use_imm = 1'b1;
            end
            OP_ORI: begin
                w_legal   = 1'b1;
                w_funct_c = 4'b0001;
                w_use_imm = 1'b1;
            end
            OP_XORI: begin
                w_legal   = 1'b1;
                w_funct_c = 4'b0100;
                w_use_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_legal   = 1'b1;
                w_funct_c = 4'b0110;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Forwarding mux for the rs path (11 falls back to the register file)
    always_comb begin
        case (fwd_sel_a)
            2'b01:   w_fwd_a = ex_fwd;
            2'b10:   w_fwd_a = mem_fwd;
            default: w_fwd_a = rs_data;
        endcase
    end

    // Forwarding mux for the rt path
    always_comb begin
        case (fwd_sel_b)
            2'b01:   w_fwd_b = ex_fwd;
            2'b10:   w_fwd_b = mem_fwd;
            default: w_fwd_b = rt_data;
        endcase
    end

    // Immediate extension and operand-B select
    always_comb begin
        w_imm_ext = w_sign_ext ? WIDTH'($signed(imm)) : WIDTH'(imm);
        w_op_b    = w_use_imm ? w_imm_ext : w_fwd_b;
    end

    assign w_in_ready = (r_cnt == '0);

    // Issue pipeline register: flush beats hold, hold beats accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct_c   <= 4'b0000;
            r_a         <= '0;
            r_b         <= '0;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_illegal <= 1'b0;
            if (flush) begin
                r_out_valid <= 1'b0;
                r_cnt       <= '0;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else if (in_valid) begin
                if (w_legal) begin
                    r_funct_c   <= w_funct_c;
                    r_a         <= w_fwd_a;
                    r_b         <= w_op_b;
                    r_out_valid <= 1'b1;
                    r_cnt       <= w_hold;
                end else begin
                    r_out_valid <= 1'b0;
                    r_illegal   <= 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_last   = r_out_valid && w_in_ready;
    assign FunctC     = r_funct_c;
    assign A          = r_a;
    assign B          = r_b;
    assign out_valid  = r_out_valid;
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard of expected issues,
// one task per scenario.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [31:0] ex_fwd;
    logic [31:0] mem_fwd;
    logic [3:0]  FunctC;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_last;
    logic        illegal_op;

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [15:0] im;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] ex;
        logic [31:0] mem;
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_issue_stage #(.WIDTH(32), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .opcode     (opcode),
        .funct      (funct),
        .imm        (imm),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .ex_fwd     (ex_fwd),
        .mem_fwd    (mem_fwd),
        .FunctC     (FunctC),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        flush     = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        imm       = 16'h0000;
        rs_data   = 32'h0;
        rt_data   = 32'h0;
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        ex_fwd    = 32'h0;
        mem_fwd   = 32'h0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [15:0] im,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [1:0] sa, input logic [1:0] sbs,
                             input logic [31:0] ex, input logic [31:0] mem);
        in_valid  = 1'b1;
        opcode    = op;
        funct     = fn;
        imm       = im;
        rs_data   = rs;
        rt_data   = rt;
        fwd_sel_a = sa;
        fwd_sel_b = sbs;
        ex_fwd    = ex;
        mem_fwd   = mem;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        n_checks++;
        if ({FunctC, A, B} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_data: got F=%b A=%h B=%h, want all zero", FunctC, A, B);
        end
        n_checks++;
        if ({out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_status: got ov/ol/ir/ill=%b, want 0010",
                     {out_valid, out_last, in_ready, illegal_op});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_add_sub();
        exp_t e;
        set_instr(6'h00, 6'h20, 16'h0, 32'h54B3D4C3, 32'h2D750177, 2'b00, 2'b00, 32'hDEAD0001, 32'hDEAD0002);
        sb_q.push_back('{f: 4'b0010, a: 32'h54B3D4C3, b: 32'h2D750177});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL add_data: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e) begin
                n_fail++;
                $display("FAIL add_data: got F=%b A=%h B=%h, want F=%b A=%h B=%h", FunctC, A, B, e.f, e.a, e.b);
            end
        end
        n_checks++;
        if ({out_valid, out_last, in_ready, illegal_op} !== 4'b1110) begin
            n_fail++;
            $display("FAIL add_status: got %b, want 1110", {out_valid, out_last, in_ready, illegal_op});
        end
        set_instr(6'h00, 6'h22, 16'h0, 32'h00000010, 32'h00000003, 2'b00, 2'b00, 32'h0, 32'h0);
        sb_q.push_back('{f: 4'b0110, a: 32'h00000010, b: 32'h00000003});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sub_data: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sub_data: got F=%b A=%h B=%h ov=%b, want F=%b A=%h B=%h ov=1",
                         FunctC, A, B, out_valid, e.f, e.a, e.b);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if ({FunctC, A, B} !== e || {out_valid, out_last, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL idle_retain: got F=%b A=%h B=%h ov/ol/ir=%b, want F=%b A=%h B=%h 001",
                     FunctC, A, B, {out_valid, out_last, in_ready}, e.f, e.a, e.b);
        end
    endtask

    task automatic test_mult_hold();
        exp_t e;
        set_instr(6'h00, 6'h18, 16'h0, 32'h12345678, 32'h9ABCDEF0, 2'b00, 2'b00, 32'h0, 32'h0);
        sb_q.push_back('{f: 4'b1010, a: 32'h12345678, b: 32'h9ABCDEF0});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL mult_data: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e) begin
                n_fail++;
                $display("FAIL mult_data: got F=%b A=%h B=%h, want F=%b A=%h B=%h", FunctC, A, B, e.f, e.a, e.b);
            end
        end
        n_checks++;
        if ({out_valid, out_last, in_ready, illegal_op} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mult_cyc1: got %b, want 1000", {out_valid, out_last, in_ready, illegal_op});
        end
        // queued add waits behind the mult, forwarded from EX/MEM
        set_instr(6'h00, 6'h20, 16'h0, 32'h11, 32'h22, 2'b01, 2'b10, 32'h55, 32'h66);
        sb_q.push_back('{f: 4'b0010, a: 32'h55, b: 32'h66});
        for (int i = 2; i <= 4; i++) begin
            tick();
            n_checks++;
            if ({FunctC, A, B} !== e ||
                {out_valid, out_last, in_ready} !== ((i == 4) ? 3'b111 : 3'b100)) begin
                n_fail++;
                $display("FAIL mult_hold_cyc%0d: got F=%b A=%h B=%h ov/ol/ir=%b, want F=%b A=%h B=%h %b",
                         i, FunctC, A, B, {out_valid, out_last, in_ready}, e.f, e.a, e.b,
                         (i == 4) ? 3'b111 : 3'b100);
            end
        end
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL mult_next_add: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e || {out_valid, out_last, in_ready} !== 3'b111) begin
                n_fail++;
                $display("FAIL mult_next_add: got F=%b A=%h B=%h ov/ol/ir=%b, want F=%b A=%h B=%h 111",
                         FunctC, A, B, {out_valid, out_last, in_ready}, e.f, e.a, e.b);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_fwd_imm();
        exp_t e;
        vec_t tbl[14];
        tbl = '{
            '{6'h08, 6'h00, 16'hFFFF, 32'hAAAA0000, 32'h0000BBBB, 2'b01, 2'b10, 32'h00000010, 32'h00000077, 4'b0010, 32'h00000010, 32'hFFFFFFFF},
            '{6'h0C, 6'h00, 16'hFFFF, 32'h00000001, 32'h00000002, 2'b00, 2'b01, 32'h00000099, 32'h00000088, 4'b0000, 32'h00000001, 32'h0000FFFF},
            '{6'h0A, 6'h00, 16'h8000, 32'h00000001, 32'h00000002, 2'b10, 2'b00, 32'h00000003, 32'h0000CAFE, 4'b0111, 32'h0000CAFE, 32'hFFFF8000},
            '{6'h0D, 6'h00, 16'h8001, 32'h00000005, 32'h00000006, 2'b11, 2'b00, 32'h00000007, 32'h00000008, 4'b0001, 32'h00000005, 32'h00008001},
            '{6'h0E, 6'h00, 16'h8000, 32'h00000021, 32'h00000022, 2'b00, 2'b00, 32'h0, 32'h0, 4'b0100, 32'h00000021, 32'h00008000},
            '{6'h23, 6'h00, 16'h8000, 32'h00001000, 32'h00000022, 2'b00, 2'b00, 32'h0, 32'h0, 4'b0010, 32'h00001000, 32'hFFFF8000},
            '{6'h2B, 6'h00, 16'h7FFF, 32'h00000031, 32'h00000032, 2'b01, 2'b01, 32'h00000003, 32'h00000004, 4'b0010, 32'h00000003, 32'h00007FFF},
            '{6'h04, 6'h00, 16'h1234, 32'h00000009, 32'h00000042, 2'b00, 2'b10, 32'h00000111, 32'h00000777, 4'b0110, 32'h00000009, 32'h00000777},
            '{6'h05, 6'h00, 16'h1234, 32'h0000000A, 32'h00000043, 2'b00, 2'b01, 32'h00000222, 32'h00000888, 4'b0110, 32'h0000000A, 32'h00000222},
            '{6'h00, 6'h26, 16'h0000, 32'h00000001, 32'h00000002, 2'b10, 2'b01, 32'hE0E0E0E0, 32'hA5A5A5A5, 4'b0100, 32'hA5A5A5A5, 32'hE0E0E0E0},
            '{6'h00, 6'h27, 16'h0000, 32'h0F0F0F0F, 32'hF00FF00F, 2'b00, 2'b11, 32'h1, 32'h2, 4'b0011, 32'h0F0F0F0F, 32'hF00FF00F},
            '{6'h00, 6'h2A, 16'h0000, 32'h80000000, 32'h00000001, 2'b00, 2'b00, 32'h0, 32'h0, 4'b0111, 32'h80000000, 32'h00000001},
            '{6'h00, 6'h25, 16'h0000, 32'h000000F0, 32'h0000000F, 2'b00, 2'b00, 32'h0, 32'h0, 4'b0001, 32'h000000F0, 32'h0000000F},
            '{6'h00, 6'h24, 16'h0000, 32'hFFFF0000, 32'h00FF00FF, 2'b11, 2'b11, 32'h0, 32'h0, 4'b0000, 32'hFFFF0000, 32'h00FF00FF}
        };
        for (int i = 0; i < 14; i++) begin
            set_instr(tbl[i].op, tbl[i].fn, tbl[i].im, tbl[i].rs, tbl[i].rt,
                      tbl[i].sa, tbl[i].sb, tbl[i].ex, tbl[i].mem);
            sb_q.push_back('{f: tbl[i].f, a: tbl[i].a, b: tbl[i].b});
            tick();
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL fwd_imm_%0d: scoreboard empty", i);
            end else begin
                e = sb_q.pop_front();
                if ({FunctC, A, B} !== e || {out_valid, out_last, in_ready, illegal_op} !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL fwd_imm_%0d: got F=%b A=%h B=%h st=%b, want F=%b A=%h B=%h st=1110",
                             i, FunctC, A, B, {out_valid, out_last, in_ready, illegal_op}, e.f, e.a, e.b);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_div_flush();
        exp_t e;
        exp_t held;
        set_instr(6'h00, 6'h1A, 16'h0, 32'h00000100, 32'h00000007, 2'b00, 2'b00, 32'h0, 32'h0);
        sb_q.push_back('{f: 4'b1111, a: 32'h00000100, b: 32'h00000007});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL div_data: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e || {out_valid, out_last, in_ready} !== 3'b100) begin
                n_fail++;
                $display("FAIL div_data: got F=%b A=%h B=%h ov/ol/ir=%b, want F=%b A=%h B=%h 100",
                         FunctC, A, B, {out_valid, out_last, in_ready}, e.f, e.a, e.b);
            end
        end
        idle_inputs();
        tick();
        tick();
        // third hold cycle: squash the div
        flush = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL div_flush: got %b, want 0010", {out_valid, out_last, in_ready, illegal_op});
        end
        flush = 1'b0;
        set_instr(6'h00, 6'h25, 16'h0, 32'h000000F0, 32'h0000000F, 2'b00, 2'b00, 32'h0, 32'h0);
        sb_q.push_back('{f: 4'b0001, a: 32'h000000F0, b: 32'h0000000F});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL post_flush_or: scoreboard empty");
        end else begin
            held = sb_q.pop_front();
            if ({FunctC, A, B} !== held || {out_valid, out_last, in_ready} !== 3'b111) begin
                n_fail++;
                $display("FAIL post_flush_or: got F=%b A=%h B=%h ov/ol/ir=%b, want F=%b A=%h B=%h 111",
                         FunctC, A, B, {out_valid, out_last, in_ready}, held.f, held.a, held.b);
            end
        end
        // flush blocks a legal accept and suppresses illegal_op
        flush = 1'b1;
        set_instr(6'h00, 6'h20, 16'h0, 32'h1234, 32'h5678, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        n_checks++;
        if ({FunctC, A, B} !== held || {out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_blocks_add: got F=%b A=%h B=%h st=%b, want F=%b A=%h B=%h st=0010",
                     FunctC, A, B, {out_valid, out_last, in_ready, illegal_op}, held.f, held.a, held.b);
        end
        set_instr(6'h3F, 6'h00, 16'h0, 32'h1, 32'h2, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        n_checks++;
        if ({FunctC, A, B} !== held || {out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_blocks_illegal: got F=%b A=%h B=%h st=%b, want F=%b A=%h B=%h st=0010",
                     FunctC, A, B, {out_valid, out_last, in_ready, illegal_op}, held.f, held.a, held.b);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_illegal();
        exp_t e;
        set_instr(6'h00, 6'h20, 16'h0, 32'h00000001, 32'h00000002, 2'b00, 2'b00, 32'h0, 32'h0);
        sb_q.push_back('{f: 4'b0010, a: 32'h00000001, b: 32'h00000002});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL pre_illegal_add: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e) begin
                n_fail++;
                $display("FAIL pre_illegal_add: got F=%b A=%h B=%h, want F=%b A=%h B=%h", FunctC, A, B, e.f, e.a, e.b);
            end
        end
        set_instr(6'h3F, 6'h00, 16'hFFFF, 32'hCAFEBABE, 32'h8BADF00D, 2'b01, 2'b01, 32'h77777777, 32'h0);
        tick();
        n_checks++;
        if ({FunctC, A, B} !== e || {out_valid, out_last, in_ready, illegal_op} !== 4'b0011) begin
            n_fail++;
            $display("FAIL illegal_opcode: got F=%b A=%h B=%h st=%b, want F=%b A=%h B=%h st=0011",
                     FunctC, A, B, {out_valid, out_last, in_ready, illegal_op}, e.f, e.a, e.b);
        end
        set_instr(6'h00, 6'h00, 16'h0, 32'hCAFEBABE, 32'h8BADF00D, 2'b00, 2'b00, 32'h0, 32'h0);
        tick();
        n_checks++;
        if ({FunctC, A, B} !== e || {out_valid, out_last, in_ready, illegal_op} !== 4'b0011) begin
            n_fail++;
            $display("FAIL illegal_funct: got F=%b A=%h B=%h st=%b, want F=%b A=%h B=%h st=0011",
                     FunctC, A, B, {out_valid, out_last, in_ready, illegal_op}, e.f, e.a, e.b);
        end
        idle_inputs();
        tick();
        n_checks++;
        if ({out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL illegal_pulse_end: got %b, want 0010", {out_valid, out_last, in_ready, illegal_op});
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        set_instr(6'h00, 6'h1A, 16'h0, 32'h00ABCDEF, 32'h00000003, 2'b00, 2'b00, 32'h0, 32'h0);
        sb_q.push_back('{f: 4'b1111, a: 32'h00ABCDEF, b: 32'h00000003});
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL div2_data: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if ({FunctC, A, B} !== e) begin
                n_fail++;
                $display("FAIL div2_data: got F=%b A=%h B=%h, want F=%b A=%h B=%h", FunctC, A, B, e.f, e.a, e.b);
            end
        end
        idle_inputs();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({FunctC, A, B} !== 68'h0 || {out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL async_reset: got F=%b A=%h B=%h st=%b, want zeros st=0010",
                     FunctC, A, B, {out_valid, out_last, in_ready, illegal_op});
        end
        #1;
        reset = 1'b0;
        tick();
        n_checks++;
        if ({FunctC, A, B} !== 68'h0 || {out_valid, out_last, in_ready, illegal_op} !== 4'b0010) begin
            n_fail++;
            $display("FAIL after_reset_idle: got F=%b A=%h B=%h st=%b, want zeros st=0010",
                     FunctC, A, B, {out_valid, out_last, in_ready, illegal_op});
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mult_hold();
        test_fwd_imm();
        test_div_flush();
        test_illegal();
        test_async_reset();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX issue stage sitting directly upstream of the ALUSelect datapath. It does four things:
- Decodes the MIPS opcode/funct into the 4-bit ALU function code FunctC.
- Applies forwarding muxes and immediate extension to build operands A and B.
- Registers FunctC, A and B into the pipeline.
- Holds them stable for multi-cycle mul/div, with a valid/ready handshake to the decode stage.

Parameters:
WIDTH, 32, datapath width of A, B and forwarded data
MUL_CYCLES, 4, cycles FunctC/A/B are held for mult (>=1)
DIV_CYCLES, 8, cycles FunctC/A/B are held for div (>=1)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  decode stage presents an instruction
in_ready  out  1  stage can accept this cycle; combinational, = (cnt==0)
flush  in  1  synchronous squash of the held/issuing instruction
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
imm  in  16  instruction[15:0]
rs_data  in  WIDTH  register-file rs value
rt_data  in  WIDTH  register-file rt value
fwd_sel_a  in  2  A source: 00 rs_data, 01 ex_fwd, 10 mem_fwd, 11 rs_data
fwd_sel_b  in  2  same encoding, applied to the rt path
ex_fwd  in  WIDTH  EX/MEM result
mem_fwd  in  WIDTH  MEM/WB result
FunctC  out  4  registered ALU function code
A  out  WIDTH  registered operand A
B  out  WIDTH  registered operand B
out_valid  out  1  FunctC/A/B hold a live instruction
out_last  out  1  out_valid && cnt==0; final cycle of the instruction
illegal_op  out  1  registered one-cycle pulse on an accepted undecodable instruction

Behaviour:
Reset (async, immediate):
- FunctC=0000, A=0, B=0, out_valid=0, illegal_op=0, cnt=0, so in_ready=1.

Decode, R-type (opcode 0x00), by funct:
- 0x20 add -> 0010
- 0x22 sub -> 0110
- 0x18 mult -> 1010
- 0x1A div -> 1111
- 0x24 and -> 0000
- 0x25 or -> 0001
- 0x27 nor -> 0011
- 0x26 xor -> 0100
- 0x2A slt -> 0111

Decode, I-type, by opcode:
- addi 0x08, lw 0x23, sw 0x2B -> 0010, sign-extended imm
- slti 0x0A -> 0111, sign-extended imm
- andi 0x0C -> 0000, zero-extended imm
- ori 0x0D -> 0001, zero-extended imm
- xori 0x0E -> 0100, zero-extended imm
- beq 0x04, bne 0x05 -> 0110, B = forwarded rt

Operand build:
- A = forwarded rs.
- R-type and branch: B = forwarded rt.
- Other I-types: B = extended imm; fwd_sel_b is ignored.

Accept (in_valid && in_ready && !flush), at the rising edge:
- Register FunctC/A/B and set out_valid=1.
- Load cnt with LAT-1: LAT = MUL_CYCLES for mult, DIV_CYCLES for div, 1 otherwise.
- Result: outputs are valid on the next edge, i.e. 1-cycle latency.

Hold:
- While cnt>0, cnt decrements each cycle.
- FunctC/A/B stay frozen and in_ready=0.
- During the final cycle (cnt==0) in_ready=1, so a new instruction issues back-to-back with no bubble.

Idle:
- If cnt==0 and no accept occurs, out_valid clears at the edge.
- FunctC/A/B retain their last values.

Illegal instruction:
- Any other opcode/funct is accepted, but out_valid stays 0, FunctC/A/B are unchanged, cnt=0.
- illegal_op=1 for exactly one cycle.

Flush:
- Has priority over both accept and hold.
- Clears out_valid and cnt, blocks the accept that cycle, and suppresses illegal_op.
- A flush during a div hold frees the stage on the next cycle.

Forwarding:
- Selects are sampled only at accept; later changes to ex_fwd/mem_fwd do not disturb a held instruction.

Test Plan:
1. reset high mid-hold of div, asynchronously, no clock edge -> immediately FunctC=0000, A=0, B=0, out_valid=0, in_ready=1.
2. R-type add, rs=0x54B3D4C3, rt=0x2D750177, fwd 00/00 -> next cycle FunctC=0010, A=0x54B3D4C3, B=0x2D750177, out_valid=1, out_last=1; back-to-back sub -> FunctC=0110 the following cycle.
3. mult, MUL_CYCLES=4 -> out_valid high 4 cycles, in_ready low for the first 3, out_last only on the 4th; a queued add issues on the 4th edge with no bubble.
4. Forwarding and immediates:
   - addi imm=0xFFFF, fwd_sel_a=01, ex_fwd=0x00000010 -> A=0x00000010, B=0xFFFFFFFF, FunctC=0010.
   - andi imm=0xFFFF -> B=0x0000FFFF.
5. div accepted, then flush asserted on the 3rd hold cycle -> out_valid=0 next edge, in_ready=1; a new or instruction issues the following cycle with FunctC=0001.
6. opcode 0x3F -> illegal_op pulses 1 cycle, out_valid=0, FunctC/A/B unchanged from the previous instruction.
